// File: rtl/clock_mode_controller_pkg.sv
// Shared encodings for the clock UI sequencer: modes, edit fields, button indices, FSM states.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_STOPWATCH = 2'd1,
    MODE_ALARM     = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_HOUR = 2'd2
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_SYNC = 2'd2
  } state_e;

  localparam int BTN_SET       = 0;
  localparam int BTN_SEL       = 1;
  localparam int BTN_CLEAR     = 2;
  localparam int BTN_MODE      = 3;
  localparam int BTN_ALARM_CLR = 4;
  localparam int BTN_SYNC      = 5;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK:     return MODE_STOPWATCH;
      MODE_STOPWATCH: return MODE_ALARM;
      default:        return MODE_CLOCK;
    endcase
  endfunction

  function automatic field_e next_field(input field_e f);
    case (f)
      FIELD_SEC: return FIELD_MIN;
      FIELD_MIN: return FIELD_HOUR;
      default:   return FIELD_SEC;
    endcase
  endfunction

  function automatic logic [2:0] field_onehot(input field_e f);
    case (f)
      FIELD_SEC:  return 3'b001;
      FIELD_MIN:  return 3'b010;
      FIELD_HOUR: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/clock_mode_controller_edit_timer.sv
// Edit-mode cycle timing: blink half-period strobe and, with SET_TIMEOUT_EN defined,
// the inactivity timeout strobe. Both restart on i_clr and stay idle while i_en is low.
module edit_timer #(
  parameter int BLINK_DIV  = 25_000_000,
  parameter int TMO_CYCLES = 1_000_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_blink_tgl,
  output logic o_timeout
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          w_blink_wrap;

  assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));
  assign o_blink_tgl  = i_en && !i_clr && w_blink_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= {BW{1'b0}};
    end else if (i_clr || !i_en || w_blink_wrap) begin
      r_blink_cnt <= {BW{1'b0}};
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

`ifdef SET_TIMEOUT_EN
  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt == TW'(TMO_CYCLES - 1));
  // A button event in the terminal cycle restarts the count rather than expiring it.
  assign o_timeout = i_en && !i_clr && w_tmo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= {TW{1'b0}};
    end else if (i_clr || !i_en || w_tmo_hit) begin
      r_tmo_cnt <= {TW{1'b0}};
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/clock_mode_controller.sv
// Clock user-interface sequencer: IDLE/EDIT/SYNC FSM driven by debounced button edges.
// Define SET_TIMEOUT_EN to leave EDIT automatically after TIMEOUT_SEC of inactivity.
module clock_mode_controller
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TIMEOUT_SEC = 10,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] btn_nedge,
  input  logic       btn_pedge,
  input  logic       sync_ack,
  output logic [1:0] mode,
  output logic       editing,
  output logic [1:0] field,
  output logic [2:0] inc,
  output logic       sw_run,
  output logic       sw_clr,
  output logic       alarm_ack,
  output logic       sync_req,
  output logic       blink
);

  state_e     r_state;
  mode_e      r_mode;
  field_e     r_field;
  logic       r_editing;
  logic [2:0] r_inc;
  logic       r_sw_run;
  logic       r_sw_clr;
  logic       r_alarm_ack;
  logic       r_sync_req;
  logic       r_blink;

  logic w_in_edit;
  logic w_tmr_clr;
  logic w_blink_tgl;
  logic w_timeout;

  assign w_in_edit = (r_state == ST_EDIT);
  assign w_tmr_clr = !w_in_edit || btn_nedge[BTN_SET] || btn_nedge[BTN_SEL] || btn_pedge;

  edit_timer #(
    .BLINK_DIV (BLINK_DIV),
    .TMO_CYCLES(CLK_FREQ * TIMEOUT_SEC)
  ) u_edit_timer (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_in_edit),
    .i_clr      (w_tmr_clr),
    .o_blink_tgl(w_blink_tgl),
    .o_timeout  (w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_CLOCK;
      r_field     <= FIELD_SEC;
      r_editing   <= 1'b0;
      r_inc       <= 3'b000;
      r_sw_run    <= 1'b0;
      r_sw_clr    <= 1'b0;
      r_alarm_ack <= 1'b0;
      r_sync_req  <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_inc       <= 3'b000;
      r_sw_clr    <= 1'b0;
      r_alarm_ack <= btn_nedge[BTN_ALARM_CLR];
      case (r_state)
        ST_IDLE: begin
          r_blink <= 1'b0;
          if (btn_nedge[BTN_SYNC] && (r_mode == MODE_CLOCK)) begin
            r_state    <= ST_SYNC;
            r_sync_req <= 1'b1;
          end else if (btn_nedge[BTN_SET]) begin
            if (r_mode == MODE_STOPWATCH) begin
              r_sw_run <= !r_sw_run;
            end else begin
              r_state   <= ST_EDIT;
              r_editing <= 1'b1;
              r_field   <= FIELD_SEC;
              r_blink   <= 1'b1;
            end
          end else if (btn_nedge[BTN_MODE]) begin
            r_mode <= next_mode(r_mode);
          end else if (btn_nedge[BTN_CLEAR] && (r_mode == MODE_STOPWATCH) && !r_sw_run) begin
            r_sw_clr <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EDIT: begin
          // Clear shares the up button, so its release is deliberately not decoded here.
          if (btn_nedge[BTN_SET] || w_timeout) begin
            r_state   <= ST_IDLE;
            r_editing <= 1'b0;
            r_blink   <= 1'b0;
          end else if (btn_nedge[BTN_SEL]) begin
            r_field <= next_field(r_field);
          end else if (btn_pedge) begin
            r_inc   <= field_onehot(r_field);
            r_blink <= 1'b1;
          end else if (w_blink_tgl) begin
            r_blink <= !r_blink;
          end else begin
            r_blink <= r_blink;
          end
        end
        ST_SYNC: begin
          if (btn_nedge[BTN_SYNC] || sync_ack) begin
            r_state    <= ST_IDLE;
            r_sync_req <= 1'b0;
          end else begin
            r_sync_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_editing  <= 1'b0;
          r_sync_req <= 1'b0;
          r_blink    <= 1'b0;
        end
      endcase
    end
  end

  assign mode      = r_mode;
  assign editing   = r_editing;
  assign field     = r_field;
  assign inc       = r_inc;
  assign sw_run    = r_sw_run;
  assign sw_clr    = r_sw_clr;
  assign alarm_ack = r_alarm_ack;
  assign sync_req  = r_sync_req;
  assign blink     = r_blink;

endmodule
